// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory controller: FSM states,
// memory-mapped device register addresses and read/write encodings.
package lc3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } lc3_state_t;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Wait-state counter width; covers WAIT_STATES up to 15.
  localparam int WCNT_W = 4;

  function automatic logic is_mmio_addr(input logic [15:0] a);
    return (a >= KBSR_ADDR) && (a <= DDR_ADDR);
  endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 keyboard/display device registers (KBSR, KBDR, DSR, DDR) and their
// strobe handshakes; only present in builds with LC3_MMIO_EN defined.
module lc3_mmio_regs
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_en,
  input  logic [15:0] rd_addr,
  output logic [15:0] rd_data,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  input  logic        disp_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data
);

  logic       kbsr_q;
  logic [7:0] kbdr_q;
  logic       dsr_q;
  logic       ddr_wr;

  assign ddr_wr = wr_en && (wr_addr == DDR_ADDR);

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      KBSR_ADDR: rd_data = {kbsr_q, 15'b0};
      KBDR_ADDR: rd_data = {8'b0, kbdr_q};
      DSR_ADDR:  rd_data = {dsr_q, 15'b0};
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kbsr_q     <= 1'b0;
      kbdr_q     <= '0;
      dsr_q      <= 1'b1;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      // A fresh character beats a simultaneous KBDR read, so the flag stays set.
      if (kbd_valid) begin
        kbsr_q <= 1'b1;
        kbdr_q <= kbd_data;
      end else if (rd_en && (rd_addr == KBDR_ADDR)) begin
        kbsr_q <= 1'b0;
      end

      disp_valid <= ddr_wr;
      if (ddr_wr) begin
        disp_data <= wr_data;
        dsr_q     <= 1'b0;
      end else if (!dsr_q && !disp_valid && disp_ready) begin
        dsr_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 main-memory controller: 2^ADDR_W x DATA_W RAM behind an IDLE/WAIT/ACK
// handshake with programmable wait states. Define LC3_MMIO_EN to decode xFE00-xFE06.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int    ADDR_W      = 16,
  parameter int    DATA_W      = 16,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_en,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              complete,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_data,
  input  logic              disp_ready,
  output logic              disp_valid,
  output logic [7:0]        disp_data
);

  lc3_state_t        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              accept;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              eff_rw;
  logic [ADDR_W-1:0] eff_addr;
  logic              rd_load;
  logic              wr_commit;
  logic              ram_we;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_en) begin
          accept  = 1'b1;
          wcnt_d  = WCNT_W'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - 1'b1;
        if (wcnt_q == WCNT_W'(1)) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      rw_q    <= RW_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (accept) begin
        rw_q    <= rw;
        addr_q  <= addr;
        wdata_q <= data_in;
      end
    end
  end

  // With zero wait states ACK follows IDLE directly, so the live request feeds the read.
  assign eff_rw    = (state_q == IDLE) ? rw   : rw_q;
  assign eff_addr  = (state_q == IDLE) ? addr : addr_q;
  assign rd_load   = (state_d == ACK) && (eff_rw == RW_READ);
  assign wr_commit = (state_q == ACK) && (rw_q == RW_WRITE);
  assign complete  = (state_q == ACK);

`ifdef LC3_MMIO_EN
  logic        rd_mmio;
  logic        wr_mmio;
  logic [15:0] mmio_rdata;

  assign rd_mmio = is_mmio_addr(16'(eff_addr));
  assign wr_mmio = is_mmio_addr(16'(addr_q));
  assign ram_we  = wr_commit && !wr_mmio;
  assign rd_data = rd_mmio ? DATA_W'(mmio_rdata) : mem[eff_addr];

  lc3_mmio_regs u_mmio (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_load && rd_mmio),
    .rd_addr    (16'(eff_addr)),
    .rd_data    (mmio_rdata),
    .wr_en      (wr_commit && wr_mmio),
    .wr_addr    (16'(addr_q)),
    .wr_data    (wdata_q[7:0]),
    .kbd_valid  (kbd_valid),
    .kbd_data   (kbd_data),
    .disp_ready (disp_ready),
    .disp_valid (disp_valid),
    .disp_data  (disp_data)
  );
`else
  logic unused_io;

  assign unused_io  = ^{kbd_valid, kbd_data, disp_ready};
  assign ram_we     = wr_commit;
  assign rd_data    = mem[eff_addr];
  assign disp_valid = 1'b0;
  assign disp_data  = '0;
`endif

  // NOTE: the RAM array has no reset; clearing 64K words is neither needed nor implementable as block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       data_out <= '0;
    else if (rd_load) data_out <= rd_data;
  end

endmodule
